// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-fed UART transmitter; define UART_TX_PARITY_EN to insert a parity bit between data and stop
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  tx_en,
  input  logic [15:0]           baud_div,
  input  logic                  stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d, div_q, div_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic stop2_q, stop2_d, txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  logic pop, bit_end, last_data, last_stop;
  assign pop = state_q == S_IDLE && tx_en && !fifo_empty;
  assign bit_end = baud_cnt_q == 16'd0;
  assign last_data = bit_cnt_q == 4'(DATA_WIDTH - 1);
  assign last_stop = !stop2_q || bit_cnt_q == 4'd1;
  // state and datapath registers; reset drops any frame in flight and returns the line to idle-high
  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      state_q <= S_IDLE;
      baud_cnt_q <= 16'd0;
      div_q <= 16'd0;
      bit_cnt_q <= 4'd0;
      shift_q <= '0;
      stop2_q <= 1'b0;
      txd_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      stop2_q <= stop2_d;
      txd_q <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  // next state: every phase except IDLE advances on the baud counter reaching zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_FETCH;
      S_FETCH:  if (bit_end) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && last_data) state_d = S_AFTER_DATA;
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:   if (bit_end && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  // counters, shifter and frame settings; settings are sampled only when the FIFO word is captured
  always_comb begin
    baud_cnt_d = bit_end ? div_q : baud_cnt_q - 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    div_d = div_q;
    stop2_d = stop2_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == S_IDLE) baud_cnt_d = pop ? 16'(RD_LATENCY - 1) : 16'd0;
    if (state_q == S_FETCH && bit_end) begin
      baud_cnt_d = baud_div;
      div_d = baud_div;
      stop2_d = stop2;
      shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
      par_d = ^fifo_rd_data ^ parity_odd;
`endif
    end
    if (state_q == S_DATA && bit_end) begin
      bit_cnt_d = last_data ? 4'd0 : bit_cnt_q + 4'd1;
      shift_d = shift_q >> 1;
    end
    if (state_q == S_STOP && bit_end) bit_cnt_d = last_stop ? 4'd0 : bit_cnt_q + 4'd1;
    txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state_d == S_PARITY) txd_d = par_q;
`endif
  end
  // outputs: pop is gated by reset so a held reset never pops; txd comes straight from its flop
  always_comb begin
    fifo_rd_en = r_rst_n && pop;
    busy = r_rst_n && (pop || state_q != S_IDLE);
    tx_done = r_rst_n && state_q == S_STOP && bit_end && last_stop;
    txd = txd_q;
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed checks of the FIFO-fed UART transmitter
module tb_uart_tx_engine;
  localparam int RL = 2;
  logic r_clk = 1'b0;
  logic r_rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic stop2 = 1'b0;
  logic [15:0] baud_div = 16'd0;
`ifdef UART_TX_PARITY_EN
  logic parity_odd = 1'b0;
`endif
  logic fifo_empty, fifo_rd_en, txd, busy, tx_done;
  logic [7:0] fifo_rd_data = 8'h3C;
  logic [7:0] st1 = 8'h3C;
  logic rd_seen = 1'b0;
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic txd_log [128];
  logic busy_log [128];
  logic done_log [128];
  logic rd_log [128];
  int e1, e2, lo_cnt, busy_cnt;

  uart_tx_engine #(.DATA_WIDTH(8), .RD_LATENCY(RL)) dut (
    .r_clk(r_clk),
    .r_rst_n(r_rst_n),
    .tx_en(tx_en),
    .baud_div(baud_div),
    .stop2(stop2),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en),
    .txd(txd),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 r_clk = ~r_clk;

  assign fifo_empty = wr_ptr == rd_ptr;

  always @(negedge r_clk) begin
    #4;
    rd_seen = fifo_rd_en;
  end

  always @(posedge r_clk) begin
    if (rd_seen) begin
      st1 <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
    fifo_rd_data <= st1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic run(input int base, input int n);
    for (int i = base; i < base + n; i++) begin
      #1;
      txd_log[i] = txd;
      busy_log[i] = busy;
      done_log[i] = tx_done;
      rd_log[i] = fifo_rd_en;
      @(negedge r_clk);
    end
  endtask

  function automatic int cnt_rd(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) c += int'(rd_log[i]);
    return c;
  endfunction

  function automatic int pexp(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return int'(^d ^ parity_odd);
`else
    return (d === 8'h00) ? -1 : -1;
`endif
  endfunction

  task automatic chk_frame(input string tag, input int s, input logic [7:0] d, input int per,
                           input int nstop, input int par, output int e);
    int nlev;
    logic want;
    nlev = 9 + (par >= 0 ? 1 : 0) + nstop;
    e = s + nlev * per - 1;
    for (int l = 0; l < nlev; l++) begin
      want = (l == 0) ? 1'b0 : (l <= 8) ? d[l-1] : (l == 9 && par >= 0) ? par[0] : 1'b1;
      for (int j = 0; j < per; j++) check({tag, "_txd"}, txd_log[s + l * per + j], want);
    end
    for (int i = s - RL - 1; i <= e; i++) begin
      check({tag, "_busy"}, busy_log[i], 1'b1);
      check({tag, "_done"}, done_log[i], i == e);
    end
  endtask

  initial begin
    repeat (3) @(negedge r_clk);
    baud_div = 16'd3;
    tx_en = 1'b1;
    push(8'hA5);
    #1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    run(0, 50);
    chk_frame("t1", 3, 8'hA5, 4, 1, pexp(8'hA5), e1);
    check("t1_rd_first", rd_log[0], 1);
    check("t1_pops", cnt_rd(0, 49), 1);
    check("t1_idle_txd", txd_log[e1 + 1], 1);
    check("t1_idle_busy", busy_log[e1 + 1], 0);
    baud_div = 16'd0;
    push(8'h00);
    push(8'hFF);
    run(0, 40);
    chk_frame("t2a", 3, 8'h00, 1, 1, pexp(8'h00), e1);
    chk_frame("t2b", e1 + 2 + RL, 8'hFF, 1, 1, pexp(8'hFF), e2);
    check("t2_pops", cnt_rd(0, 39), 2);
    check("t2_rd2", rd_log[e1 + 1], 1);
    for (int i = e1 + 1; i <= e1 + 1 + RL; i++) check("t2_gap", txd_log[i], 1);
    check("t2_end_busy", busy_log[e2 + 1], 0);
    run(0, 100);
    lo_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      lo_cnt += int'(!txd_log[i]);
      busy_cnt += int'(busy_log[i]);
    end
    check("t4_pops", cnt_rd(0, 99), 0);
    check("t4_txd_low", lo_cnt, 0);
    check("t4_busy", busy_cnt, 0);
    baud_div = 16'd1;
    stop2 = 1'b1;
    push(8'h81);
    run(0, 6);
    baud_div = 16'd5;
    stop2 = 1'b0;
    tx_en = 1'b0;
    push(8'h55);
    run(6, 30);
    chk_frame("t3", 3, 8'h81, 2, 2, pexp(8'h81), e1);
    check("t3_pops", cnt_rd(0, 35), 1);
    check("t3_idle_busy", busy_log[e1 + 1], 0);
    check("t3_idle_txd", txd_log[35], 1);
    baud_div = 16'd3;
    tx_en = 1'b1;
    run(0, 20);
    r_rst_n = 1'b0;
    run(20, 1);
    r_rst_n = 1'b1;
    tx_en = 1'b0;
    run(21, 30);
    check("t5_rd_first", rd_log[0], 1);
    check("t5_bit2", txd_log[16], 1);
    check("t5_bit3", txd_log[20], 0);
    for (int i = 0; i <= 20; i++) check("t5_no_done_pre", done_log[i], 0);
    for (int i = 21; i <= 50; i++) begin
      check("t5_txd", txd_log[i], 1);
      check("t5_busy", busy_log[i], 0);
      check("t5_done", done_log[i], 0);
    end
    check("t5_pops", cnt_rd(0, 50), 1);
    baud_div = 16'd0;
    tx_en = 1'b1;
    push(8'hC3);
    run(0, 20);
    chk_frame("t6", 3, 8'hC3, 1, 1, pexp(8'hC3), e1);
    check("t6_pops", cnt_rd(0, 19), 1);
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
    push(8'h07);
    run(0, 20);
    chk_frame("t7e", 3, 8'h07, 1, 1, 1, e1);
    check("t7e_par", txd_log[12], 1);
    check("t7e_len", e1, 13);
    parity_odd = 1'b1;
    push(8'h07);
    run(0, 20);
    chk_frame("t7o", 3, 8'h07, 1, 1, 0, e1);
    check("t7o_par", txd_log[12], 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
